// File: rtl/router_pkt_reader_if.sv
// Signal bundle between one router output port and its packet reader.
// The reader side uses the master modport; the router/client side uses slave.
interface router_pkt_reader_if;
    logic       vld_out;
    logic [7:0] data_in;
    logic       soft_reset;
    logic       rd_en;
    logic [7:0] byte_out;
    logic       byte_vld;
    logic [1:0] pkt_addr;
    logic [5:0] pkt_len;
    logic       pkt_done;
    logic       parity_err;
    logic       addr_err;
    logic       pkt_abort;
    logic       busy;
    logic [7:0] pkt_cnt;
    logic [7:0] err_cnt;

    modport master (
        input  vld_out, data_in, soft_reset,
        output rd_en, byte_out, byte_vld, pkt_addr, pkt_len, pkt_done,
               parity_err, addr_err, pkt_abort, busy, pkt_cnt, err_cnt
    );

    modport slave (
        output vld_out, data_in, soft_reset,
        input  rd_en, byte_out, byte_vld, pkt_addr, pkt_len, pkt_done,
               parity_err, addr_err, pkt_abort, busy, pkt_cnt, err_cnt
    );
endinterface

// File: rtl/router_pkt_reader.sv
// Destination-side packet consumer for one router output port: backs off, drains
// header/payload/parity from the FIFO, checks parity and address, aborts on flush.
module router_pkt_reader #(
    parameter logic [1:0]  PORT_ID     = 2'd0,
    parameter int unsigned WAIT_CYCLES = 5
) (
    input logic                 clk,
    input logic                 rst,
    router_pkt_reader_if.master bus
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WAIT    = 3'd1;
    localparam logic [2:0] HDR_RD  = 3'd2;
    localparam logic [2:0] HDR_CAP = 3'd3;
    localparam logic [2:0] BODY    = 3'd4;

    localparam int unsigned WAIT_LAST_I = (WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1;
    localparam logic [4:0]  WAIT_LAST   = 5'(WAIT_LAST_I);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [4:0] wait_cnt;
    logic [6:0] remaining;
    logic [6:0] received;
    logic [7:0] acc;
    logic       rd_en_c;
    logic       rd_en_q;
    logic       abort;
    logic       capture;
    logic       last_byte;
    logic       perr;
    logic       aerr;

    logic [7:0] byte_out_r;
    logic       byte_vld_r;
    logic [1:0] pkt_addr_r;
    logic [5:0] pkt_len_r;
    logic       pkt_done_r;
    logic       parity_err_r;
    logic       addr_err_r;
    logic       pkt_abort_r;
    logic [7:0] pkt_cnt_r;
    logic [7:0] err_cnt_r;

    // Flush only matters once a packet is in progress.
    assign abort     = bus.soft_reset && (state != IDLE);
    // rd_en_q marks the cycle the FIFO presents the byte requested one cycle earlier.
    assign capture   = rd_en_q && (state == BODY);
    assign last_byte = (received == {1'b0, pkt_len_r});
    assign perr      = (acc ^ bus.data_in) != 8'h00;
    assign aerr      = pkt_addr_r != PORT_ID;

    always_comb begin
        state_nxt = state;
        rd_en_c   = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.vld_out) begin
                        state_nxt = (WAIT_CYCLES == 0) ? HDR_RD : WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state_nxt = HDR_RD;
                    end
                end
                HDR_RD: begin
                    rd_en_c   = 1'b1;
                    state_nxt = HDR_CAP;
                end
                HDR_CAP: begin
                    state_nxt = BODY;
                end
                BODY: begin
                    rd_en_c = bus.vld_out && (remaining != '0);
                    if (capture && last_byte) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            rd_en_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            rd_en_q <= rd_en_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt     <= '0;
            remaining    <= '0;
            received     <= '0;
            acc          <= '0;
            byte_out_r   <= '0;
            byte_vld_r   <= 1'b0;
            pkt_addr_r   <= '0;
            pkt_len_r    <= '0;
            pkt_done_r   <= 1'b0;
            parity_err_r <= 1'b0;
            addr_err_r   <= 1'b0;
            pkt_abort_r  <= 1'b0;
            pkt_cnt_r    <= '0;
            err_cnt_r    <= '0;
        end else begin
            byte_vld_r   <= 1'b0;
            pkt_done_r   <= 1'b0;
            parity_err_r <= 1'b0;
            addr_err_r   <= 1'b0;
            pkt_abort_r  <= 1'b0;
            if (abort) begin
                pkt_abort_r <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        wait_cnt <= '0;
                    end
                    WAIT: begin
                        wait_cnt <= wait_cnt + 5'd1;
                    end
                    HDR_CAP: begin
                        pkt_len_r  <= bus.data_in[7:2];
                        pkt_addr_r <= bus.data_in[1:0];
                        acc        <= bus.data_in;
                        remaining  <= {1'b0, bus.data_in[7:2]} + 7'd1;
                        received   <= '0;
                    end
                    BODY: begin
                        if (rd_en_c) begin
                            remaining <= remaining - 7'd1;
                        end
                        if (capture) begin
                            received <= received + 7'd1;
                            if (last_byte) begin
                                pkt_done_r   <= 1'b1;
                                parity_err_r <= perr;
                                addr_err_r   <= aerr;
                                pkt_cnt_r    <= pkt_cnt_r + 8'd1;
                                if (perr || aerr) begin
                                    err_cnt_r <= err_cnt_r + 8'd1;
                                end
                            end else begin
                                byte_out_r <= bus.data_in;
                                byte_vld_r <= 1'b1;
                                acc        <= acc ^ bus.data_in;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.rd_en      = rd_en_c;
    assign bus.busy       = (state != IDLE);
    assign bus.byte_out   = byte_out_r;
    assign bus.byte_vld   = byte_vld_r;
    assign bus.pkt_addr   = pkt_addr_r;
    assign bus.pkt_len    = pkt_len_r;
    assign bus.pkt_done   = pkt_done_r;
    assign bus.parity_err = parity_err_r;
    assign bus.addr_err   = addr_err_r;
    assign bus.pkt_abort  = pkt_abort_r;
    assign bus.pkt_cnt    = pkt_cnt_r;
    assign bus.err_cnt    = err_cnt_r;
endmodule

// File: tb/tb_router_pkt_reader.sv
// Scoreboard bench for router_pkt_reader: a FIFO model feeds packets, a reference
// model queues expected bytes/completions/aborts, and a monitor compares outputs.
module tb_router_pkt_reader;
    localparam logic [1:0] PORT_ID     = 2'd0;
    localparam int         WAIT_CYCLES = 5;

    typedef struct {
        int len;
        int addr;
        int perr;
        int aerr;
        int cnt;
        int ecnt;
        int lat;
    } done_t;

    logic clk;
    logic rst;
    bit   starve;
    int   checks;
    int   failures;
    int   exp_cnt;
    int   exp_err;
    int   cyc;
    int   busy_start;
    bit   busy_prev;

    logic [7:0] fifo[$];
    logic [7:0] pay_q[$];
    logic [7:0] exp_bytes[$];
    done_t      exp_done[$];
    int         exp_abort[$];

    router_pkt_reader_if bus();

    router_pkt_reader #(.PORT_ID(PORT_ID), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=present expected=absent (t=%0t)", name, $time);
    endtask

    // FIFO model: samples rd_en just before the edge, presents data 1 cycle later.
    always @(negedge clk) begin
        logic rd, sr, rs, bz, vo, st;
        #4;
        rd = bus.rd_en;
        sr = bus.soft_reset;
        rs = rst;
        bz = bus.busy;
        vo = bus.vld_out;
        st = starve;
        if (rd) check("fifo_underflow", int'(fifo.size() == 0), 0);
        if (sr && bz) check("rd_en_on_abort", int'(rd), 0);
        if (!bz) check("rd_en_idle", int'(rd), 0);
        if (st && !vo && bz) check("rd_en_starved", int'(rd), 0);
        @(posedge clk);
        #1;
        if (sr || !rs) fifo.delete();
        else if (rd && fifo.size() != 0) bus.data_in = fifo.pop_front();
        bus.vld_out = (fifo.size() != 0) && !starve;
    end

    // Monitor: compares every DUT output event against the scoreboard queues.
    always @(negedge clk) begin
        done_t d;
        logic [7:0] eb;
        int ea;
        cyc++;
        if (bus.busy && !busy_prev) busy_start = cyc;
        busy_prev = bus.busy;
        if (bus.byte_vld) begin
            if (exp_bytes.size() == 0) flag_fail("unexpected_byte");
            else begin
                eb = exp_bytes.pop_front();
                check("byte_out", int'(bus.byte_out), int'(eb));
            end
        end
        if (bus.pkt_done) begin
            if (exp_done.size() == 0) flag_fail("unexpected_pkt_done");
            else begin
                d = exp_done.pop_front();
                check("pkt_len", int'(bus.pkt_len), d.len);
                check("pkt_addr", int'(bus.pkt_addr), d.addr);
                check("parity_err", int'(bus.parity_err), d.perr);
                check("addr_err", int'(bus.addr_err), d.aerr);
                check("pkt_cnt", int'(bus.pkt_cnt), d.cnt);
                check("err_cnt", int'(bus.err_cnt), d.ecnt);
                check("bytes_before_done", exp_bytes.size(), 0);
                if (d.lat >= 0) check("done_latency", cyc - busy_start, d.lat);
            end
        end else begin
            check("err_flags_without_done", int'({bus.parity_err, bus.addr_err}), 0);
        end
        if (bus.pkt_abort) begin
            if (exp_abort.size() == 0) flag_fail("unexpected_pkt_abort");
            else begin
                ea = exp_abort.pop_front();
                check("abort_pkt_cnt", int'(bus.pkt_cnt), ea);
                check("abort_byte_vld", int'(bus.byte_vld), 0);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_rd_en"}, int'(bus.rd_en), 0);
        check({tag, "_byte_out"}, int'(bus.byte_out), 0);
        check({tag, "_byte_vld"}, int'(bus.byte_vld), 0);
        check({tag, "_pkt_addr"}, int'(bus.pkt_addr), 0);
        check({tag, "_pkt_len"}, int'(bus.pkt_len), 0);
        check({tag, "_flags"}, int'({bus.pkt_done, bus.parity_err, bus.addr_err, bus.pkt_abort}), 0);
        check({tag, "_pkt_cnt"}, int'(bus.pkt_cnt), 0);
        check({tag, "_err_cnt"}, int'(bus.err_cnt), 0);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_bytes.size() != 0 || exp_done.size() != 0 || exp_abort.size() != 0 ||
                bus.busy || fifo.size() != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", int'(t >= 3000), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic fill_random(input logic [5:0] len);
        pay_q.delete();
        for (int i = 0; i < int'(len); i++) pay_q.push_back(8'($urandom_range(0, 255)));
    endtask

    // mode: 0 clean, 1 starve after k bytes, 2 soft_reset after k bytes, 3 rst after k bytes
    task automatic send_pkt(input logic [5:0] len, input logic [1:0] addr, input bit bad_par,
                            input int mode, input int k);
        logic [7:0] hdr;
        logic [7:0] par;
        done_t d;
        int seen;
        int t;
        hdr = {len, addr};
        par = hdr;
        foreach (pay_q[i]) par ^= pay_q[i];
        if (bad_par) par ^= 8'h01;
        foreach (pay_q[i]) if (mode < 2 || i < k) exp_bytes.push_back(pay_q[i]);
        if (mode < 2) begin
            d.len  = int'(len);
            d.addr = int'(addr);
            d.perr = int'(bad_par);
            d.aerr = int'(addr != PORT_ID);
            exp_cnt = (exp_cnt + 1) % 256;
            if (bad_par || addr != PORT_ID) exp_err = (exp_err + 1) % 256;
            d.cnt  = exp_cnt;
            d.ecnt = exp_err;
            d.lat  = (mode == 0) ? WAIT_CYCLES + int'(len) + 4 : -1;
            exp_done.push_back(d);
        end else if (mode == 2) begin
            exp_abort.push_back(exp_cnt);
        end
        fifo.push_back(hdr);
        foreach (pay_q[i]) fifo.push_back(pay_q[i]);
        fifo.push_back(par);
        if (mode != 0) begin
            seen = 0;
            t = 0;
            while (seen < k && t < 500) begin
                @(negedge clk);
                t++;
                if (bus.byte_vld) seen++;
            end
            check("trigger_timeout", int'(seen < k), 0);
            case (mode)
                1: begin
                    starve = 1'b1;
                    repeat (10) @(negedge clk);
                    starve = 1'b0;
                end
                2: begin
                    bus.soft_reset = 1'b1;
                    @(negedge clk);
                    bus.soft_reset = 1'b0;
                end
                default: begin
                    rst = 1'b0;
                    exp_cnt = 0;
                    exp_err = 0;
                    @(negedge clk);
                    check_all_zero("mid_reset");
                    rst = 1'b1;
                end
            endcase
        end
        wait_drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] len;
        logic [1:0] addr;
        int mode;
        int k;
        rst = 1'b0;
        starve = 1'b0;
        bus.soft_reset = 1'b0;
        repeat (4) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        pay_q = '{8'h11, 8'h22, 8'h33};
        send_pkt(6'd3, 2'd0, 1'b0, 0, 0);
        send_pkt(6'd3, 2'd0, 1'b1, 0, 0);
        pay_q.delete();
        send_pkt(6'd0, 2'd2, 1'b0, 0, 0);
        fill_random(6'd6);
        send_pkt(6'd6, 2'd0, 1'b0, 1, 2);
        fill_random(6'd5);
        send_pkt(6'd5, 2'd0, 1'b0, 2, 2);
        fill_random(6'd4);
        send_pkt(6'd4, 2'd0, 1'b0, 0, 0);
        fill_random(6'd5);
        send_pkt(6'd5, 2'd1, 1'b1, 3, 2);
        fill_random(6'd2);
        send_pkt(6'd2, 2'd0, 1'b0, 0, 0);
        fill_random(6'd63);
        send_pkt(6'd63, 2'd0, 1'b0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            len  = 6'($urandom_range(0, 24));
            addr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : PORT_ID;
            mode = 0;
            k = 0;
            if (len >= 1 && $urandom_range(0, 3) == 0) begin
                mode = $urandom_range(1, 3);
                k = (mode == 1 && len >= 2) ? $urandom_range(1, int'(len) - 1)
                                            : $urandom_range(1, int'(len));
                if (mode == 1 && len < 2) mode = 0;
            end
            fill_random(len);
            send_pkt(len, addr, ($urandom_range(0, 3) == 0), mode, k);
        end

        check("leftover_expectations", exp_bytes.size() + exp_done.size() + exp_abort.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/router_pkt_reader.md
# router_pkt_reader

Destination-side packet consumer for one output port of the 1x3 router. It watches the port's `vld_out`, waits a programmable back-off, then drains one packet from the output FIFO: header, payload, then parity byte. It checks parity and address, streams payload bytes to the client, and aborts cleanly when the router's timeout `soft_reset` flushes the FIFO. Three instances sit at the router boundary, one per output port, and their `rd_en` drives the router's `rd_en_0/1/2`.

## Interface
- `PORT_ID`, default 2'd0: expected header address for this instance.
- `WAIT_CYCLES`, default 5: back-off cycles between detecting `vld_out` and the header read. Legal range is 0..27, which keeps the router's 30-cycle timeout from firing.
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-low.
- `vld_out` input 1: FIFO non-empty, from the router.
- `data_in` input 8: FIFO read data. It is registered in the FIFO and valid the cycle after `rd_en`=1.
- `soft_reset` input 1: router timeout flush for this port.
- `rd_en` output 1: FIFO read strobe (combinational from state).
- `byte_out` output 8: payload byte (registered).
- `byte_vld` output 1: one-cycle pulse, `byte_out` valid.
- `pkt_addr` output 2: header[1:0] of the last packet. Held until the next header.
- `pkt_len` output 6: header[7:2] of the last packet. Held until the next header.
- `pkt_done` output 1: one-cycle pulse, packet fully drained.
- `parity_err` output 1: pulse coincident with `pkt_done`.
- `addr_err` output 1: pulse coincident with `pkt_done`.
- `pkt_abort` output 1: one-cycle pulse, packet dropped by `soft_reset`.
- `busy` output 1: state != IDLE.
- `pkt_cnt` output 8: completed packets, wraps at 255→0.
- `err_cnt` output 8: completed packets with any error, wraps at 255→0.

## Operation
**Packet format**
- Header byte: {len[5:0], addr[1:0]}.
- Then `len` payload bytes, then one parity byte.
- Parity is good when the XOR of header, all payload bytes and the parity byte is 8'h00.
- len=0 is legal: header then parity only.

**States**
- IDLE: `rd_en`=0. `vld_out`=1 → WAIT, with the wait counter cleared; if `WAIT_CYCLES`=0, go directly to HDR_RD.
- WAIT: counter increments each cycle. When it reaches `WAIT_CYCLES`-1 → HDR_RD.
- HDR_RD: `rd_en`=1 for exactly one cycle → HDR_CAP.
- HDR_CAP: `rd_en`=0. On this edge:
  - capture `data_in` into `pkt_len`/`pkt_addr`;
  - load the parity accumulator with the header;
  - remaining := len+1;
  - received := 0;
  - → BODY.
- BODY: `rd_en` = `vld_out` && remaining≠0; remaining decrements on each issued read.
  - A registered `rd_en_q` marks capture cycles; on each capture received increments.
  - If received < len, the byte is payload: `byte_out`<=`data_in`, `byte_vld`<=1, XOR it into the accumulator.
  - If received == len, the byte is parity:
    - `pkt_done`<=1;
    - `parity_err`<= (acc ^ `data_in`) ≠ 0;
    - `addr_err`<= `pkt_addr` ≠ `PORT_ID`;
    - `pkt_cnt`++;
    - `err_cnt`++ if either error (once per packet);
    - → IDLE.
- If `vld_out` drops in BODY, reads pause with no timeout and no error.

**Abort**
- `soft_reset`=1 in any state except IDLE: `rd_en` forced 0 that cycle; next state IDLE; `pkt_abort`<=1.
- No `pkt_done`, no `byte_vld`, counters unchanged.
- `soft_reset` in IDLE is ignored.
- Abort wins over a simultaneous parity capture.

**Reset**
- `rst`=0 at any edge: state IDLE; all outputs and counters 0.
- Reset mid-packet drops the packet with no `pkt_abort` pulse.

## Timing
- `rd_en` is never high in IDLE, WAIT or HDR_CAP.
- Read-to-data latency is 1 cycle. `byte_vld` is high the cycle after the byte is on `data_in`.
- With the FIFO holding the whole packet, `pkt_done` is high exactly `WAIT_CYCLES`+len+4 cycles after the first WAIT cycle.
- BODY issues len+1 back-to-back reads; the final capture cycle has `rd_en`=0.
- A new packet cannot be detected until the cycle after `pkt_done` (IDLE re-entry). Minimum gap from `pkt_done` to the next `rd_en` is `WAIT_CYCLES`+1 cycles.
- Flags are 1-cycle pulses; all are 0 otherwise.

## Test plan
- **Good packet:** `WAIT_CYCLES`=5, `PORT_ID`=0; FIFO preloaded with 8'h0C, 8'h11, 8'h22, 8'h33, parity 8'h0C^8'h11^8'h22^8'h33.
  - `byte_out` = 11, 22, 33 on consecutive cycles.
  - `pkt_done` 12 cycles after WAIT entry; `pkt_len`=3; no errors; `pkt_cnt`=1.
- **Corrupted parity:** same packet, parity byte XOR 8'h01 → `pkt_done`+`parity_err`; `err_cnt`=1; `pkt_cnt`=1.
- **len=0, wrong address:** header 8'h02, `PORT_ID`=0, parity 8'h02 → zero `byte_vld`; `pkt_done` at `WAIT_CYCLES`+4; `addr_err`=1; `parity_err`=0.
- **Starved FIFO:** `vld_out` low for 10 cycles mid-payload → `rd_en` low throughout; resumes after; correct bytes and `pkt_done`; no abort.
- **Flush mid-packet:** `soft_reset` pulse after 2 payload bytes → `rd_en` 0 that cycle; `pkt_abort` next cycle; IDLE; counters unchanged. The next packet is received correctly.
- **Reset mid-BODY:** `rst`=0 for 1 cycle → all outputs 0; `busy`=0; no `pkt_done`.
